eth_phy_tx_if_pat: RTL and testbench

ETH_PHY_TX_IF_PAT -- requirements
Module: eth_phy_tx_if_pat

---
 rtl/eth_phy_tx_if_pat.sv | 121 ++++++++++++
 tb/tb_eth_phy_tx_if_pat.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_phy_tx_if_pat.sv
// eth_phy_tx_if_pat: 64b/66b SERDES TX interface with x^58+x^39+1 scrambler, bit-0 error injection and output pipeline.
// Optional PRBS31 / square-wave test patterns are built only with ETH_PHY_TX_TEST_PATTERN_EN defined.
module eth_phy_tx_if_pat #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH = 2,
  parameter bit BIT_REVERSE = 0,
  parameter bit SCRAMBLER_DISABLE = 0,
  parameter int SERDES_PIPELINE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  input  logic                  encoded_tx_hdr_valid,
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  output logic                  serdes_tx_hdr_valid,
  input  logic [1:0]            tx_test_mode,
  output logic                  tx_test_active,
  input  logic                  tx_err_inject,
  output logic                  tx_err_inject_ack
);
  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || HDR_WIDTH != 2 || SERDES_PIPELINE < 0 || SERDES_PIPELINE > 4) begin : g_bad_param
    $error("eth_phy_tx_if_pat: illegal DATA_WIDTH, HDR_WIDTH or SERDES_PIPELINE");
  end
  logic                  boundary, err_pend, unused_ok;
  logic [57:0]           scr_q, scr_d;
  logic [DATA_WIDTH-1:0] scr_data, norm_data, pat_data, err_data, out_data;
  logic [HDR_WIDTH-1:0]  pat_hdr, out_hdr;
  logic [SERDES_PIPELINE:0][DATA_WIDTH-1:0] pipe_data;
  logic [SERDES_PIPELINE:0][HDR_WIDTH-1:0]  pipe_hdr;
  logic [SERDES_PIPELINE:0]                 pipe_hv, pipe_ack;
  assign boundary = DATA_WIDTH == 64 ? 1'b1 : encoded_tx_hdr_valid;
  assign unused_ok = ^{encoded_tx_hdr_valid, tx_test_mode};
  // scrambler runs on every input word regardless of mode, so normal mode resumes without reseed
  always_comb begin
    scr_d = scr_q;
    scr_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      scr_data[i] = encoded_tx_data[i] ^ scr_d[38] ^ scr_d[57];
      scr_d = {scr_d[56:0], scr_data[i]};
    end
  end
  assign norm_data = SCRAMBLER_DISABLE ? encoded_tx_data : scr_data;
`ifdef ETH_PHY_TX_TEST_PATTERN_EN
  localparam int PW = HDR_WIDTH + DATA_WIDTH;
  typedef enum logic [1:0] {MODE_NORMAL = 2'd0, MODE_PRBS = 2'd1, MODE_SQUARE = 2'd2} mode_t;
  mode_t                mode_q, mode;
  logic [30:0]          prbs_q, prbs_d;
  logic [PW-1:0]        prbs_bits;
  logic [HDR_WIDTH-1:0] prbs_hdr_q;
  assign mode = !boundary ? mode_q : tx_test_mode == 2'd1 ? MODE_PRBS : tx_test_mode == 2'd2 ? MODE_SQUARE : MODE_NORMAL;
  // header words take HDR_WIDTH+DATA_WIDTH generator bits, first bits land in the header
  always_comb begin
    prbs_d = prbs_q;
    prbs_bits = '0;
    for (int k = 0; k < PW; k++)
      if (k < (boundary ? PW : DATA_WIDTH)) begin
        prbs_bits[k] = prbs_d[30] ^ prbs_d[27];
        prbs_d = {prbs_d[29:0], prbs_bits[k]};
      end
  end
  assign pat_data = mode == MODE_PRBS ? (boundary ? ~prbs_bits[PW-1:HDR_WIDTH] : ~prbs_bits[DATA_WIDTH-1:0]) :
                    mode == MODE_SQUARE ? {(DATA_WIDTH/16){16'h00FF}} : norm_data;
  assign pat_hdr = mode == MODE_PRBS ? (boundary ? ~prbs_bits[HDR_WIDTH-1:0] : prbs_hdr_q) :
                   mode == MODE_SQUARE ? HDR_WIDTH'(1) : encoded_tx_hdr;
  assign tx_test_active = mode_q != MODE_NORMAL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= MODE_NORMAL;
      prbs_q <= '1;
      prbs_hdr_q <= '0;
    end else begin
      mode_q <= mode;
      prbs_q <= mode == MODE_PRBS ? prbs_d : prbs_q;
      prbs_hdr_q <= mode == MODE_PRBS && boundary ? ~prbs_bits[HDR_WIDTH-1:0] : prbs_hdr_q;
    end
`else
  assign pat_data = norm_data;
  assign pat_hdr = encoded_tx_hdr;
  assign tx_test_active = 1'b0;
`endif
  always_comb begin
    err_data = pat_data ^ DATA_WIDTH'(err_pend);
    out_data = '0;
    out_hdr = '0;
    for (int i = 0; i < DATA_WIDTH; i++) out_data[i] = BIT_REVERSE ? err_data[DATA_WIDTH-1-i] : err_data[i];
    for (int i = 0; i < HDR_WIDTH; i++) out_hdr[i] = BIT_REVERSE ? pat_hdr[HDR_WIDTH-1-i] : pat_hdr[i];
  end
  // a request arriving while one is pending (or being applied) is dropped, not queued
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scr_q <= '1;
      err_pend <= 1'b0;
    end else begin
      scr_q <= scr_d;
      err_pend <= !err_pend && tx_err_inject;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pipe_data <= '0;
      pipe_hdr <= '0;
      pipe_hv <= '0;
      pipe_ack <= '0;
    end else begin
      pipe_data[0] <= out_data;
      pipe_hdr[0] <= out_hdr;
      pipe_hv[0] <= boundary;
      pipe_ack[0] <= err_pend;
      for (int i = 1; i <= SERDES_PIPELINE; i++) begin
        pipe_data[i] <= pipe_data[i-1];
        pipe_hdr[i] <= pipe_hdr[i-1];
        pipe_hv[i] <= pipe_hv[i-1];
        pipe_ack[i] <= pipe_ack[i-1];
      end
    end
  assign serdes_tx_data = pipe_data[SERDES_PIPELINE];
  assign serdes_tx_hdr = pipe_hdr[SERDES_PIPELINE];
  assign serdes_tx_hdr_valid = pipe_hv[SERDES_PIPELINE];
  assign tx_err_inject_ack = pipe_ack[SERDES_PIPELINE];
endmodule

// File: tb/tb_eth_phy_tx_if_pat.sv
// tb_eth_phy_tx_if_pat: directed bench over three configurations of eth_phy_tx_if_pat
// (64b scrambled, 64b bypass with 2-stage pipeline, 32b bypass bit-reversed).
module tb_eth_phy_tx_if_pat;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [63:0] data = '0;
  logic [1:0] hdr = '0, mode = '0;
  logic hv = 1'b0, err = 1'b0;
  logic [63:0] o0_data, o1_data, exp0;
  logic [31:0] o2_data;
  logic [1:0] o0_hdr, o1_hdr, o2_hdr;
  logic o0_hv, o1_hv, o2_hv, act0, act1, act2, ack0, ack1, ack2;
  int checks = 0, failures = 0;
  bit hist[$];
  bit pb[$];
  localparam logic [63:0] K = 64'hA5A5_0000_FFFF_1234;

  always #5 clk = ~clk;

  eth_phy_tx_if_pat #(.DATA_WIDTH(64)) d0 (
    .clk(clk), .rst_n(rst_n), .encoded_tx_data(data), .encoded_tx_hdr(hdr), .encoded_tx_hdr_valid(hv),
    .serdes_tx_data(o0_data), .serdes_tx_hdr(o0_hdr), .serdes_tx_hdr_valid(o0_hv),
    .tx_test_mode(mode), .tx_test_active(act0), .tx_err_inject(err), .tx_err_inject_ack(ack0));
  eth_phy_tx_if_pat #(.DATA_WIDTH(64), .SCRAMBLER_DISABLE(1), .SERDES_PIPELINE(2)) d1 (
    .clk(clk), .rst_n(rst_n), .encoded_tx_data(data), .encoded_tx_hdr(hdr), .encoded_tx_hdr_valid(hv),
    .serdes_tx_data(o1_data), .serdes_tx_hdr(o1_hdr), .serdes_tx_hdr_valid(o1_hv),
    .tx_test_mode(mode), .tx_test_active(act1), .tx_err_inject(err), .tx_err_inject_ack(ack1));
  eth_phy_tx_if_pat #(.DATA_WIDTH(32), .SCRAMBLER_DISABLE(1), .BIT_REVERSE(1)) d2 (
    .clk(clk), .rst_n(rst_n), .encoded_tx_data(data[31:0]), .encoded_tx_hdr(hdr), .encoded_tx_hdr_valid(hv),
    .serdes_tx_data(o2_data), .serdes_tx_hdr(o2_hdr), .serdes_tx_hdr_valid(o2_hv),
    .tx_test_mode(mode), .tx_test_active(act2), .tx_err_inject(err), .tx_err_inject_ack(ack2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic seed();
    hist = {};
    repeat (58) hist.push_back(1'b1);
  endtask

  // reference scrambler over a bit history: s[n] = d[n] ^ s[n-39] ^ s[n-58]
  function automatic logic [63:0] scr_next(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) begin
      r[i] = d[i] ^ hist[hist.size() - 39] ^ hist[hist.size() - 58];
      hist.push_back(r[i]);
      hist.delete(0);
    end
    return r;
  endfunction

  task automatic cyc(input logic [63:0] d, input logic [1:0] h, input logic v, input logic e);
    data = d;
    hdr = h;
    hv = v;
    err = e;
    exp0 = scr_next(d);
    @(posedge clk);
    #1;
  endtask

  task automatic collect();
    if (o2_hv) begin
      pb.push_back(~o2_hdr[1]);
      pb.push_back(~o2_hdr[0]);
    end
    for (int i = 0; i < 32; i++) pb.push_back(~o2_data[31-i]);
  endtask

  initial begin
    int errs, acks, flips, both, ones;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d0_data", o0_data, 64'h0);
    chk("rst_d0_hdr", o0_hdr, 2'b00);
    chk("rst_d0_hv", o0_hv, 1'b0);
    chk("rst_d0_active", act0, 1'b0);
    chk("rst_d1_data", o1_data, 64'h0);
    chk("rst_d1_ack", ack1, 1'b0);
    chk("rst_d2_data", o2_data, 64'h0);
    chk("rst_d2_hv", o2_hv, 1'b0);
    seed();
    rst_n = 1'b1;

    cyc(64'h0, 2'b10, 1'b1, 1'b0);
    chk("scr_first_word", o0_data, 64'h03FF_FF80_0000_0000);
    chk("scr_first_hdr", o0_hdr, 2'b10);
    chk("scr_first_hv", o0_hv, 1'b1);
    errs = 0;
    for (int n = 1; n < 1000; n++) begin
      cyc(64'h0, 2'b10, 1'b1, 1'b0);
      if (o0_data !== exp0 || o0_hdr !== 2'b10) errs++;
    end
    chk("scr_1000_word_errors", errs, 0);

    cyc(64'h0123_4567_89AB_CDEF, 2'b01, 1'b1, 1'b0);
    chk("scr_nonzero_word", o0_data, exp0);
    chk("rev32_data", o2_data, 32'hF7B3_D591);
    chk("rev32_hdr", o2_hdr, 2'b10);
    chk("rev32_hv", o2_hv, 1'b1);
    chk("bypass_not_early", o1_data, 64'h0);
    cyc(64'h0, 2'b00, 1'b0, 1'b0);
    chk("hv32_low", o2_hv, 1'b0);
    chk("hv64_const", o0_hv, 1'b1);
    chk("bypass_not_early2", o1_data, 64'h0);
    cyc(64'h0, 2'b00, 1'b1, 1'b0);
    chk("bypass_data", o1_data, 64'h0123_4567_89AB_CDEF);
    chk("bypass_hdr", o1_hdr, 2'b01);
    chk("bypass_hv", o1_hv, 1'b1);

    repeat (3) cyc(K, 2'b10, 1'b1, 1'b0);
    cyc(K, 2'b10, 1'b1, 1'b1);
    chk("err_p1_ack", ack2, 1'b0);
    chk("err_p1_data", o2_data, 32'h2C48_FFFF);
    cyc(K, 2'b10, 1'b1, 1'b1);
    chk("err_flip_ack", ack2, 1'b1);
    chk("err_flip_data", o2_data, 32'hAC48_FFFF);
    acks = 0; flips = 0; both = 0;
    for (int n = 0; n < 5; n++) begin
      cyc(K, 2'b10, 1'b1, 1'b0);
      if (n == 0) begin
        chk("err_dropped_ack", ack2, 1'b0);
        chk("err_dropped_data", o2_data, 32'h2C48_FFFF);
      end
      acks += int'(ack1);
      flips += int'(o1_data !== K);
      both += int'(ack1 && o1_data === (K ^ 64'h1));
    end
    chk("err_ack_count", acks, 1);
    chk("err_flip_count", flips, 1);
    chk("err_ack_on_flip", both, 1);
    cyc(K, 2'b10, 1'b1, 1'b1);
    cyc(K, 2'b10, 1'b1, 1'b0);
    chk("err_later_ack", ack2, 1'b1);
    chk("err_later_data", o2_data, 32'hAC48_FFFF);
    cyc(K, 2'b10, 1'b1, 1'b0);
    chk("scr_after_err", o0_data, exp0);

`ifdef ETH_PHY_TX_TEST_PATTERN_EN
    mode = 2'd2;
    cyc(64'h0, 2'b10, 1'b1, 1'b0);
    chk("sq_active64", act0, 1'b1);
    chk("sq_active_pipe", act1, 1'b1);
    chk("sq_active32", act2, 1'b1);
    chk("sq_d0_data", o0_data, 64'h00FF_00FF_00FF_00FF);
    chk("sq_d0_hdr", o0_hdr, 2'b01);
    chk("sq_d2_data", o2_data, 32'hFF00_FF00);
    chk("sq_d2_hdr", o2_hdr, 2'b10);
    chk("sq_pipe_early", o1_data, K);
    cyc(64'h0, 2'b10, 1'b1, 1'b0);
    cyc(64'h0, 2'b10, 1'b1, 1'b0);
    chk("sq_pipe_data", o1_data, 64'h00FF_00FF_00FF_00FF);
    chk("sq_pipe_hdr", o1_hdr, 2'b01);
    mode = 2'd0;
    cyc(64'h0, 2'b10, 1'b1, 1'b0);
    chk("resume_no_reseed", o0_data, exp0);
    chk("resume_inactive", act0, 1'b0);
    mode = 2'd1;
    cyc(64'h0, 2'b01, 1'b0, 1'b0);
    chk("prbs_defer32", act2, 1'b0);
    chk("prbs_now64", act0, 1'b1);
    pb = {};
    for (int n = 0; n < 40; n++) begin
      cyc(64'h0, 2'b01, 1'b1, 1'b0);
      if (n == 0) chk("prbs_switch_at_hv", act2, 1'b1);
      collect();
      cyc(64'h0, 2'b01, 1'b0, 1'b0);
      collect();
    end
    errs = 0; ones = 0;
    foreach (pb[n]) begin
      ones += int'(pb[n]);
      if (n >= 31 && pb[n] != (pb[n-31] ^ pb[n-28])) errs++;
    end
    chk("prbs_bits", pb.size(), 40 * 66);
    chk("prbs_errors", errs, 0);
    chk("prbs_nonconst", ones > 0 && ones < pb.size(), 1'b1);
`else
    mode = 2'd2;
    cyc(64'h1111_2222_3333_4444, 2'b01, 1'b1, 1'b0);
    chk("mode_ignored_active", act0, 1'b0);
    chk("mode_ignored_active32", act2, 1'b0);
    chk("mode_ignored_data", o0_data, exp0);
    mode = 2'd1;
    cyc(64'h5555_6666_7777_8888, 2'b01, 1'b1, 1'b0);
    chk("mode_ignored_prbs", o0_data, exp0);
    chk("mode_ignored_hdr", o0_hdr, 2'b01);
`endif

    cyc(K, 2'b10, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_d0", o0_data, 64'h0);
    chk("async_rst_d1", o1_data, 64'h0);
    chk("async_rst_d2", o2_data, 64'h0);
    chk("async_rst_active", act0, 1'b0);
    chk("async_rst_hdr", o0_hdr, 2'b00);
    mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    seed();
    rst_n = 1'b1;
    cyc(64'h0, 2'b01, 1'b1, 1'b0);
    chk("post_rst_seed", o0_data, 64'h03FF_FF80_0000_0000);
    chk("post_rst_active", act0, 1'b0);
    cyc(64'hDEAD_BEEF_0000_0001, 2'b01, 1'b1, 1'b0);
    chk("post_rst_scr", o0_data, exp0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
